uart_cmd_driver: RTL and testbench

UART_CMD_DRIVER -- requirements
Module: uart_cmd_driver

---
 rtl/uart_cmd_driver_if.sv | 27 ++
 rtl/uart_cmd_driver.sv | 213 +++++++++++++++++++++
 tb/tb_uart_cmd_driver.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_driver_if.sv
// Command-word handshake, frame configuration and line/status bundle for uart_cmd_driver.
interface uart_cmd_driver_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
);
    logic [DATA_WIDTH-1:0]     CMD_DATA;
    logic                      CMD_VALID;
    logic                      CMD_READY;
    logic                      PAR_EN;
    logic                      PAR_TYP;
    logic [PRESCALE_WIDTH-1:0] PRESCALE;
    logic                      TX_LINE;
    logic                      BUSY;
    logic                      FRAME_DONE;
    logic                      FIFO_FULL;
    logic                      FIFO_EMPTY;

    modport master (
        output CMD_DATA, CMD_VALID, PAR_EN, PAR_TYP, PRESCALE,
        input  CMD_READY, TX_LINE, BUSY, FRAME_DONE, FIFO_FULL, FIFO_EMPTY
    );

    modport slave (
        input  CMD_DATA, CMD_VALID, PAR_EN, PAR_TYP, PRESCALE,
        output CMD_READY, TX_LINE, BUSY, FRAME_DONE, FIFO_FULL, FIFO_EMPTY
    );
endinterface

// File: rtl/uart_cmd_driver.sv
// Buffered UART transmitter: FIFO of command words serialised as start/data/parity/stop frames.
// Optional feature macro INTER_FRAME_GAP_EN adds GAP_BITS idle bit-times after every stop bit.
module uart_cmd_driver #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6,
    parameter int FIFO_DEPTH     = 8,
    parameter int GAP_BITS       = 1
) (
    input  logic             UART_CLK,
    input  logic             RST,
    uart_cmd_driver_if.slave cmd
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [PRESCALE_WIDTH-1:0] MIN_PRESCALE = PRESCALE_WIDTH'(4);

`ifdef INTER_FRAME_GAP_EN
    localparam int GW = $clog2(GAP_BITS + 1);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_GAP    = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;
`endif

    function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] word, input logic odd);
        return (^word) ^ odd;
    endfunction

    function automatic logic [PRESCALE_WIDTH-1:0] clamp_prescale(input logic [PRESCALE_WIDTH-1:0] p);
        return (p < MIN_PRESCALE) ? MIN_PRESCALE : p;
    endfunction

    logic [DATA_WIDTH-1:0]     mem_r [FIFO_DEPTH];
    logic [AW:0]               wr_ptr_r;
    logic [AW:0]               rd_ptr_r;
    state_t                    state_r;
    logic [PRESCALE_WIDTH-1:0] cyc_cnt_r;
    logic [PRESCALE_WIDTH-1:0] presc_r;
    logic [BW-1:0]             bit_cnt_r;
    logic [DATA_WIDTH-1:0]     shift_r;
    logic                      par_en_r;
    logic                      par_bit_r;
    logic                      tx_line_r;
    logic                      busy_r;
    logic                      frame_done_r;
`ifdef INTER_FRAME_GAP_EN
    logic [GW-1:0]             gap_cnt_r;
`endif

    logic full_s;
    logic empty_s;
    logic push_s;
    logic pop_s;
    logic bit_end_s;
    logic frame_end_s;
    logic line_s;

    // FIFO flags, bit timing and the point at which the next frame may start.
    always_comb begin
        full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        empty_s   = (wr_ptr_r == rd_ptr_r);
        push_s    = cmd.CMD_VALID && !full_s;
        bit_end_s = (cyc_cnt_r == (presc_r - PRESCALE_WIDTH'(1)));
        frame_end_s = 1'b0;
        case (state_r)
            ST_IDLE: frame_end_s = 1'b1;
`ifdef INTER_FRAME_GAP_EN
            ST_GAP:  frame_end_s = bit_end_s && (gap_cnt_r == GW'(GAP_BITS - 1));
`else
            ST_STOP: frame_end_s = bit_end_s;
`endif
            default: frame_end_s = 1'b0;
        endcase
        pop_s = frame_end_s && !empty_s;
    end

    // Line level for the current state; registered one cycle later into tx_line_r.
    always_comb begin
        line_s = 1'b1;
        case (state_r)
            ST_START:  line_s = 1'b0;
            ST_DATA:   line_s = shift_r[0];
            ST_PARITY: line_s = par_bit_r;
            default:   line_s = 1'b1;
        endcase
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge UART_CLK) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= cmd.CMD_DATA;
        end
    end

    // FIFO pointers with an extra wrap bit separating full from empty.
    always_ff @(posedge UART_CLK) begin
        if (!RST) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

    // Frame sequencer and registered line/status outputs.
    always_ff @(posedge UART_CLK) begin
        if (!RST) begin
            state_r      <= ST_IDLE;
            cyc_cnt_r    <= '0;
            presc_r      <= '0;
            bit_cnt_r    <= '0;
            shift_r      <= '0;
            par_en_r     <= 1'b0;
            par_bit_r    <= 1'b0;
            tx_line_r    <= 1'b1;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
`ifdef INTER_FRAME_GAP_EN
            gap_cnt_r    <= '0;
`endif
        end else begin
            tx_line_r    <= line_s;
            busy_r       <= (state_r != ST_IDLE);
            frame_done_r <= (state_r == ST_STOP) && bit_end_s;
            if (pop_s) begin
                // Word and framing options are captured here so later input changes cannot corrupt the frame.
                shift_r   <= mem_r[rd_ptr_r[AW-1:0]];
                par_bit_r <= parity_bit(mem_r[rd_ptr_r[AW-1:0]], cmd.PAR_TYP);
                par_en_r  <= cmd.PAR_EN;
                presc_r   <= clamp_prescale(cmd.PRESCALE);
                cyc_cnt_r <= '0;
                bit_cnt_r <= '0;
                state_r   <= ST_START;
            end else begin
                cyc_cnt_r <= bit_end_s ? '0 : cyc_cnt_r + PRESCALE_WIDTH'(1);
                case (state_r)
                    ST_IDLE: begin
                        cyc_cnt_r <= '0;
                    end
                    ST_START: begin
                        if (bit_end_s) begin
                            state_r <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (bit_end_s) begin
                            shift_r <= shift_r >> 1;
                            if (bit_cnt_r == BW'(DATA_WIDTH - 1)) begin
                                bit_cnt_r <= '0;
                                state_r   <= par_en_r ? ST_PARITY : ST_STOP;
                            end else begin
                                bit_cnt_r <= bit_cnt_r + BW'(1);
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (bit_end_s) begin
                            state_r <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        if (bit_end_s) begin
`ifdef INTER_FRAME_GAP_EN
                            gap_cnt_r <= '0;
                            state_r   <= ST_GAP;
`else
                            state_r   <= ST_IDLE;
`endif
                        end
                    end
`ifdef INTER_FRAME_GAP_EN
                    ST_GAP: begin
                        if (bit_end_s) begin
                            if (gap_cnt_r == GW'(GAP_BITS - 1)) begin
                                state_r <= ST_IDLE;
                            end else begin
                                gap_cnt_r <= gap_cnt_r + GW'(1);
                            end
                        end
                    end
`endif
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign cmd.CMD_READY  = !full_s;
    assign cmd.FIFO_FULL  = full_s;
    assign cmd.FIFO_EMPTY = empty_s;
    assign cmd.TX_LINE    = tx_line_r;
    assign cmd.BUSY       = busy_r;
    assign cmd.FRAME_DONE = frame_done_r;
endmodule

// File: tb/tb_uart_cmd_driver.sv
// Self-checking bench for uart_cmd_driver: directed scenarios plus random traffic against a bit-stream model.
`timescale 1ns/1ps
module tb_uart_cmd_driver;
    localparam int DW    = 8;
    localparam int PW    = 6;
    localparam int DEPTH = 8;
`ifdef INTER_FRAME_GAP_EN
    localparam int GAPB  = 2;
`else
    localparam int GAPB  = 1;
`endif
    // {TX_LINE, BUSY, FRAME_DONE} on an idle line
    localparam logic [2:0] LINE_IDLE = 3'b100;

    logic clk_s = 1'b0;
    logic rst_s = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_seen = 0;
    logic [2:0]    line_q [$];
    logic [DW-1:0] fifo_q [$];
    logic [5:0]    exp_s;
    logic [5:0]    obs_s;

    uart_cmd_driver_if #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) bus ();

    uart_cmd_driver #(
        .DATA_WIDTH(DW), .PRESCALE_WIDTH(PW), .FIFO_DEPTH(DEPTH), .GAP_BITS(GAPB)
    ) dut (
        .UART_CLK(clk_s),
        .RST(rst_s),
        .cmd(bus)
    );

    always #5 clk_s = ~clk_s;

    // Expands one word into the per-cycle line waveform it must produce.
    task automatic queue_frame(input logic [DW-1:0] w, input logic pe, input logic pt, input int presc);
        logic bits_a [$];
        int   p;
        p = (presc < 4) ? 4 : presc;
        bits_a.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits_a.push_back(w[i]);
        if (pe) bits_a.push_back((^w) ^ pt);
        bits_a.push_back(1'b1);
        for (int b = 0; b < bits_a.size(); b++)
            for (int c = 0; c < p; c++)
                line_q.push_back({bits_a[b], 1'b1, (b == bits_a.size() - 1) && (c == p - 1)});
`ifdef INTER_FRAME_GAP_EN
        repeat (GAPB * p) line_q.push_back(3'b110);
`endif
    endtask

    task automatic step();
        logic [2:0]    line_e;
        logic [DW-1:0] w;
        int            cnt0;
        @(posedge clk_s);
        if (!rst_s) begin
            line_q.delete();
            fifo_q.delete();
            line_e = LINE_IDLE;
        end else begin
            line_e = (line_q.size() > 0) ? line_q.pop_front() : LINE_IDLE;
            cnt0 = fifo_q.size();
            if (line_q.size() == 0 && cnt0 > 0) begin
                w = fifo_q.pop_front();
                queue_frame(w, bus.PAR_EN, bus.PAR_TYP, int'(bus.PRESCALE));
            end
            if (bus.CMD_VALID && cnt0 < DEPTH) fifo_q.push_back(bus.CMD_DATA);
        end
        exp_s = {line_e, fifo_q.size() == 0, fifo_q.size() == DEPTH, fifo_q.size() != DEPTH};
        #1;
        obs_s = {bus.TX_LINE, bus.BUSY, bus.FRAME_DONE, bus.FIFO_EMPTY, bus.FIFO_FULL, bus.CMD_READY};
        if (bus.FRAME_DONE === 1'b1) done_seen++;
        n_cmp++;
        assert (obs_s === exp_s) else begin
            n_bad++;
            $error("FAIL line_status t=%0t observed=%b expected=%b (tx,busy,done,empty,full,ready)", $time, obs_s, exp_s);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        bus.CMD_DATA  = w;
        bus.CMD_VALID = 1'b1;
        step();
        bus.CMD_VALID = 1'b0;
    endtask

    task automatic run_idle(input int max_cycles);
        int k;
        k = 0;
        while ((line_q.size() > 0 || fifo_q.size() > 0) && k < max_cycles) begin
            step();
            k++;
        end
        n_cmp++;
        assert (k < max_cycles) else begin
            n_bad++;
            $error("FAIL drain_timeout observed=%0d cycles expected below %0d", k, max_cycles);
        end
    endtask

    task automatic check_done(input string tag, input int expected);
        n_cmp++;
        assert (done_seen === expected) else begin
            n_bad++;
            $error("FAIL %s observed=%0d pulses expected=%0d", tag, done_seen, expected);
        end
        done_seen = 0;
    endtask

    initial begin
        bus.CMD_DATA  = '0;
        bus.CMD_VALID = 1'b0;
        bus.PAR_EN    = 1'b0;
        bus.PAR_TYP   = 1'b0;
        bus.PRESCALE  = 6'd8;
        rst_s = 1'b0;
        repeat (3) step();
        rst_s = 1'b1;
        step();

        // 0xAA, even parity, 32 cycles per bit
        bus.PRESCALE = 6'd32; bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b0;
        done_seen = 0;
        push_word(8'hAA);
        run_idle(500);
        check_done("aa_frame_done", 1);

        // five back-to-back frames without parity
        bus.PAR_EN = 1'b0; bus.PRESCALE = 6'd8;
        push_word(8'hBB); push_word(8'h0A); push_word(8'hCC); push_word(8'h35); push_word(8'h88);
        run_idle(1000);
        check_done("b2b_frame_done", 5);

        // overfill while the first frame is on the line
        push_word(8'h11);
        repeat (3) step();
        for (int i = 0; i < 9; i++) push_word(8'(8'h20 + i));
        n_cmp++;
        assert (bus.CMD_READY === 1'b0 && bus.FIFO_FULL === 1'b1) else begin
            n_bad++;
            $error("FAIL full_flags observed ready=%b full=%b expected ready=0 full=1", bus.CMD_READY, bus.FIFO_FULL);
        end
        run_idle(2000);
        check_done("full_frame_done", 9);

        // odd parity, prescale below the minimum
        bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b1; bus.PRESCALE = 6'd2;
        push_word(8'hDD);
        run_idle(200);
        check_done("odd_frame_done", 1);

        // reset in data bit 3 of 0x42
        bus.PAR_EN = 1'b0; bus.PRESCALE = 6'd8;
        push_word(8'h42);
        push_word(8'h43);
        repeat (4 * 8 + 3) step();
        rst_s = 1'b0;
        step();
        n_cmp++;
        assert (bus.TX_LINE === 1'b1 && bus.FIFO_EMPTY === 1'b1 && bus.BUSY === 1'b0) else begin
            n_bad++;
            $error("FAIL abort_state observed tx=%b empty=%b busy=%b expected 1 1 0", bus.TX_LINE, bus.FIFO_EMPTY, bus.BUSY);
        end
        rst_s = 1'b1;
        repeat (20) step();
        check_done("abort_frame_done", 0);

        // random traffic with mid-frame option changes
        for (int i = 0; i < 2500; i++) begin
            bus.CMD_VALID = ($urandom_range(0, 3) == 0);
            bus.CMD_DATA  = 8'($urandom);
            if ($urandom_range(0, 40) == 0) begin
                bus.PAR_EN   = 1'($urandom);
                bus.PAR_TYP  = 1'($urandom);
                bus.PRESCALE = 6'($urandom_range(0, 7));
            end
            step();
        end
        bus.CMD_VALID = 1'b0;
        run_idle(3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
